speed_ctrl: RTL
===============

SPEED_CTRL -- requirements
Module: speed_ctrl

Interface
REQ-001 Parameter UUID, default 0, instance identifier XORed into child UUIDs.
REQ-002 Parameter NAME, default "", instance label; no functional effect.
REQ-003 Parameter DEBOUNCE_CYCLES, default 32'd500000, consecutive stable cycles required to accept a button change; legal range 1..2^20.
REQ-004 Parameter BASE_CYCLE, default 32'd195312, cycle count at fastest level.
REQ-005 Parameter RESET_LEVEL, default 3'd4, speed level after reset.
REQ-006 clk  input  1  single clock, rising-edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 btn_up  input  1  raw asynchronous push-button, high = pressed, raises speed.
REQ-009 btn_dn  input  1  raw asynchronous push-button, high = pressed, lowers speed.
REQ-010 btn_mode  input  1  raw asynchronous push-button, high = pressed, toggles hex/decimal.
REQ-011 cycle  output  32  clocks per count step, drives counter cycle input.
REQ-012 hex  output  1  display mode, 1 = hex, drives counter hex input.
REQ-013 level  output  3  current speed level, 0 = slowest, 7 = fastest.
REQ-014 changed  output  1  one-cycle pulse when level or hex changed.

Function
REQ-015 Each button SHALL pass through its own 2-flop synchronizer; no raw input SHALL reach any other logic.
REQ-016 Each button SHALL have a debounced-state flop and a 20-bit counter: counter increments each cycle sync value != debounced value, clears when equal.
REQ-017 Debounced state SHALL flip on the edge where the counter has seen DEBOUNCE_CYCLES consecutive disagreeing cycles; counter clears on that edge.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no debounced change.
REQ-019 Press pulse (per button) SHALL be registered: high exactly one cycle following the debounced 0->1 transition; release produces no pulse.
REQ-020 Raw input held high from edge E SHALL give its press pulse during the cycle after edge E+DEBOUNCE_CYCLES+2; level/hex update on the next edge.
REQ-021 up pulse alone: level = level+1, saturating at 7; no change and no changed pulse at 7.
REQ-022 dn pulse alone: level = level-1, saturating at 0; no change and no changed pulse at 0.
REQ-023 up and dn pulses in the same cycle: level unchanged, no changed pulse.
REQ-024 mode pulse: hex inverts; independent of simultaneous up/dn handling.
REQ-025 changed SHALL be high for exactly the one cycle after the edge that altered level or hex; simultaneous level and hex change gives one pulse.
REQ-026 cycle SHALL equal BASE_CYCLE << (7 - level), 32-bit, derived only from the level register (glitch-free, zero extra latency); overflow bits discarded.
REQ-027 Holding a button indefinitely SHALL produce exactly one press pulse (no auto-repeat).

Reset
REQ-028 rst high SHALL asynchronously force: synchronizers 0, debounced states 0, counters 0, pulses 0, level = RESET_LEVEL, hex = 0, changed = 0.
REQ-029 After reset, cycle SHALL equal BASE_CYCLE << (7 - RESET_LEVEL) (default 195312*8 = 1562496).
REQ-030 A button held through rst deassertion SHALL be treated as a fresh press: one pulse after DEBOUNCE_CYCLES+2 further edges.
REQ-031 Reset asserted mid-debounce SHALL discard partial count; no pulse after release of rst unless the button is still held.

Verification (DEBOUNCE_CYCLES = 4, BASE_CYCLE = 100)
REQ-032 Reset: rst pulse -> level = 4, hex = 0, cycle = 800, changed = 0.
REQ-033 btn_up high at edge 0 and held -> up pulse in cycle after edge 6, level = 5, cycle = 400, one changed pulse; no further change while held.
REQ-034 btn_dn high for 3 cycles then low -> no pulse, level stays 4, changed stays 0.
REQ-035 Five separated btn_up presses from level 4 -> level 5, 6, 7, 7, 7; cycle ends at 100; exactly three changed pulses.
REQ-036 btn_up and btn_dn rising on the same edge, with btn_mode -> level unchanged at 4, hex = 1, exactly one changed pulse.
REQ-037 btn_mode held, rst asserted after 2 debounce cycles then released -> hex = 0 through reset, then hex = 1 after 6 further edges plus one.

Source files
------------

// File: rtl/speed_ctrl.sv
// speed_ctrl -- three-button speed / display-mode controller.
//
// Purpose:
//   Synchronises and debounces three raw push-buttons, turns each debounced
//   press into a single-cycle pulse, and uses those pulses to step a 3-bit
//   speed level (saturating 0..7) and toggle a hex/decimal display flag.
//   The counter period "cycle" is derived combinationally from the level
//   register so it changes on the same edge as level, with no glitches.
//
// Ports:
//   clk       in   1   single rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   btn_up    in   1   raw button, high = pressed, raises speed
//   btn_dn    in   1   raw button, high = pressed, lowers speed
//   btn_mode  in   1   raw button, high = pressed, toggles hex/decimal
//   cycle     out  32  clocks per count step = BASE_CYCLE << (7 - level)
//   hex       out  1   display mode, 1 = hex
//   level     out  3   speed level, 0 = slowest, 7 = fastest
//   changed   out  1   one-cycle pulse after the edge that altered level/hex
module speed_ctrl #(
  parameter int          UUID            = 0,
  parameter              NAME            = "",
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500000,
  parameter logic [31:0] BASE_CYCLE      = 32'd195312,
  parameter logic [2:0]  RESET_LEVEL     = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        btn_mode,
  output logic [31:0] cycle,
  output logic        hex,
  output logic [2:0]  level,
  output logic        changed
);

  // Terminal count: the debounced state flips on the edge where the counter
  // already holds DEBOUNCE_CYCLES-1, i.e. on the DEBOUNCE_CYCLES-th
  // consecutive disagreeing cycle.
  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 32'd1);

  localparam int BTN_UP   = 0;
  localparam int BTN_DN   = 1;
  localparam int BTN_MODE = 2;

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_mode, btn_dn, btn_up};

  // One identical synchroniser / debouncer / press detector per button.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        deb_q, deb_d;
    logic        deb_dly_q, deb_dly_d;
    logic        press_q, press_d;
    logic [19:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d   = btn_raw[gi];
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      cnt_d     = '0;
      deb_dly_d = deb_q;
      // Counter only runs while the synchronised input disagrees with the
      // debounced state; any agreement restarts the run from zero.
      if (sync2_q != deb_q) begin
        if (cnt_q == DB_LAST) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      // Rising edge of the debounced state, registered one cycle later.
      press_d = deb_q & ~deb_dly_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        deb_q     <= 1'b0;
        deb_dly_q <= 1'b0;
        press_q   <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        deb_q     <= deb_d;
        deb_dly_q <= deb_dly_d;
        press_q   <= press_d;
        cnt_q     <= cnt_d;
      end
    end

    assign press[gi] = press_q;
  end

  logic [2:0] level_q, level_d;
  logic       hex_q, hex_d;
  logic       changed_q, changed_d;

  always_comb begin
    level_d = level_q;
    hex_d   = hex_q;
    // Simultaneous up and down cancel; saturation suppresses the change.
    if (press[BTN_UP] && !press[BTN_DN] && (level_q != 3'd7)) begin
      level_d = level_q + 3'd1;
    end else if (press[BTN_DN] && !press[BTN_UP] && (level_q != 3'd0)) begin
      level_d = level_q - 3'd1;
    end
    if (press[BTN_MODE]) begin
      hex_d = ~hex_q;
    end
    changed_d = (level_d != level_q) || (hex_d != hex_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= RESET_LEVEL;
      hex_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      hex_q     <= hex_d;
      changed_q <= changed_d;
    end
  end

  // Pure function of the level register: same-edge update, no extra flop.
  assign cycle   = BASE_CYCLE << (3'd7 - level_q);
  assign level   = level_q;
  assign hex     = hex_q;
  assign changed = changed_q;

endmodule
